// File: rtl/mac_poly_pkg.sv
// mac_poly_pkg: shared constants and helpers for the Horner polynomial evaluator.
package mac_poly_pkg;
    localparam int STAGE_LAT = 3;

    function automatic int clog2_guard(input int order);
        return $clog2(order + 1);
    endfunction

    function automatic int total_lat(input int order);
        return STAGE_LAT * order + 1;
    endfunction

    // Clamp a badd-bit signed value (carried in 64 bits) to the signed bc-bit range
    function automatic logic signed [63:0] sat_bc(input logic signed [63:0] v, input int badd, input int bc);
        logic signed [63:0] x, hi, lo;
        x = (v <<< (64 - badd)) >>> (64 - badd);
        hi = (64'sd1 <<< (bc - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bc - 1));
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction
endpackage

// File: rtl/mac_poly_n_stage.sv
// poly_stage: one Horner MAC stage, y_o = c + ((y * t) >>> BT), 3-cycle latency, t forwarded alongside.
module poly_stage #(
    parameter int BADD = 19,
    parameter int BT   = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic signed [BADD-1:0] y_i,
    input  logic        [BT-1:0]   t_i,
    input  logic signed [BADD-1:0] c_i,
    output logic signed [BADD-1:0] y_o,
    output logic        [BT-1:0]   t_o
);
    localparam int BP = BADD + BT + 1;
    logic signed [BADD-1:0] y_q, c_q, c2_q, s_q, s_d;
    logic        [BT-1:0]   t_q, t2_q, t3_q;
    logic signed [BP-1:0]   p_q, p_d;
    // t is zero-extended so the multiply stays signed without reinterpreting t's top bit
    assign p_d = BP'(y_q) * BP'($signed({1'b0, t_q}));
    assign s_d = c2_q + BADD'(p_q >>> BT);
    always_ff @(posedge clk) begin
        if (!rstn) begin
            {y_q, c_q, t_q, p_q, c2_q, t2_q, s_q, t3_q} <= '0;
        end else begin
            y_q  <= y_i;
            c_q  <= c_i;
            t_q  <= t_i;
            p_q  <= p_d;
            c2_q <= c_q;
            t2_q <= t_q;
            s_q  <= s_d;
            t3_q <= t2_q;
        end
    end
    assign y_o = s_q;
    assign t_o = t3_q;
endmodule

// File: rtl/mac_poly_n.sv
// mac_poly_n: pipelined Horner polynomial evaluator with saturating output and sticky overflow.
// Define MAC_POLY_ROUND_EN for round-half-up output quantisation instead of truncation.
module mac_poly_n
    import mac_poly_pkg::*;
#(
    parameter int ORDER = 5,
    parameter int BC    = 16,
    parameter int BT    = 16,
    parameter int BY    = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [BT-1:0]           t_in,
    input  logic [(ORDER+1)*BC-1:0] c_in,
    input  logic                    in_valid,
    input  logic                    ovf_clr,
    output logic [BY-1:0]           y_out,
    output logic                    y_valid,
    output logic                    ovf
);
    localparam int BADD = BC + clog2_guard(ORDER);
    localparam int L    = total_lat(ORDER);
    logic signed [BADD-1:0] cx [ORDER+1];
    logic signed [BADD-1:0] yk [ORDER+1];
    logic        [BT-1:0]   tk [ORDER+1];
    logic signed [BADD:0]   yr;
    logic signed [BC-1:0]   ys;
    logic        [L-1:0]    vld_q;
    logic        [BY-1:0]   y_q, y_d;
    logic                   ovf_q, ovf_d, sat;

    for (genvar i = 0; i <= ORDER; i++) begin : g_cx
        assign cx[i] = BADD'($signed(c_in[i*BC +: BC]));
    end
    assign yk[0] = cx[ORDER];
    assign tk[0] = t_in;

    for (genvar k = 0; k < ORDER; k++) begin : g_st
        logic signed [BADD-1:0] c_k;
        if (k == 0) begin : g_nd
            assign c_k = cx[ORDER-1];
        end else begin : g_dl
            // Holds this stage's coefficient until its sample's partial sum arrives
            logic signed [BADD-1:0] dl_q [STAGE_LAT*k];
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    dl_q <= '{default: '0};
                end else begin
                    dl_q[0] <= cx[ORDER-1-k];
                    for (int i = 1; i < STAGE_LAT*k; i++) dl_q[i] <= dl_q[i-1];
                end
            end
            assign c_k = dl_q[STAGE_LAT*k-1];
        end
        poly_stage #(.BADD(BADD), .BT(BT)) u_stage (
            .clk  (clk),
            .rstn (rstn),
            .y_i  (yk[k]),
            .t_i  (tk[k]),
            .c_i  (c_k),
            .y_o  (yk[k+1]),
            .t_o  (tk[k+1])
        );
    end

`ifdef MAC_POLY_ROUND_EN
    localparam int RSH = (BY < BC) ? BC - BY - 1 : 0;
    localparam logic signed [BADD:0] RND = (BY < BC) ? (BADD+1)'(2 ** RSH) : '0;
    assign yr = (BADD+1)'(yk[ORDER]) + RND;
`else
    assign yr = (BADD+1)'(yk[ORDER]);
`endif
    assign ys    = BC'(sat_bc(64'(yr), BADD + 1, BC));
    assign sat   = (BADD+1)'(ys) != yr;
    assign y_d   = ys[BC-1 -: BY];
    // A new saturation wins over a simultaneous clear
    assign ovf_d = (sat && vld_q[L-2]) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q <= '0;
            y_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            vld_q <= {vld_q[L-2:0], in_valid};
            y_q   <= y_d;
            ovf_q <= ovf_d;
        end
    end
    assign y_out   = y_q;
    assign y_valid = vld_q[L-1];
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_mac_poly_n.sv
// tb_mac_poly_n: self-checking bench for mac_poly_n against a plain-arithmetic Horner model.
module tb_mac_poly_n;
    localparam int ORDER = 5, BC = 16, BT = 16, BY = 16, BY8 = 8;
    localparam int L  = 3 * ORDER + 1;
    localparam int CW = (ORDER + 1) * BC;

    logic          clk = 0, rstn = 0, in_valid = 0, ovf_clr = 0;
    logic [BT-1:0] t_in = '0;
    logic [CW-1:0] c_in = '0;
    logic [BY-1:0] y_out;
    logic [BY8-1:0] y_out8;
    logic          y_valid, ovf, y_valid8, ovf8;
    int            chk = 0, pass = 0;

    always #5 clk = ~clk;

    mac_poly_n #(.ORDER(ORDER), .BC(BC), .BT(BT), .BY(BY)) u_dut (
        .clk(clk), .rstn(rstn), .t_in(t_in), .c_in(c_in), .in_valid(in_valid),
        .ovf_clr(ovf_clr), .y_out(y_out), .y_valid(y_valid), .ovf(ovf)
    );
    mac_poly_n #(.ORDER(ORDER), .BC(BC), .BT(BT), .BY(BY8)) u_dut8 (
        .clk(clk), .rstn(rstn), .t_in(t_in), .c_in(c_in), .in_valid(in_valid),
        .ovf_clr(ovf_clr), .y_out(y_out8), .y_valid(y_valid8), .ovf(ovf8)
    );

    typedef struct {bit v; bit s; bit s8; logic [BY-1:0] y; logic [BY8-1:0] y8;} ent_t;
    ent_t pq[$];
    bit exp_v, exp_ovf, exp_ovf8;
    logic [BY-1:0] exp_y;
    logic [BY8-1:0] exp_y8;

    // Reference: evaluate the polynomial directly with 64-bit integers, floor shifts, clamp, then select
    function automatic longint eval(input logic [BT-1:0] t, input logic [CW-1:0] c, input int by, output bit s);
        longint acc, lim;
        acc = longint'($signed(c[ORDER*BC +: BC]));
        for (int k = ORDER - 1; k >= 0; k--)
            acc = longint'($signed(c[k*BC +: BC])) + ((acc * longint'(t)) >>> BT);
`ifdef MAC_POLY_ROUND_EN
        if (by < BC) acc += longint'(1) << (BC - by - 1);
`endif
        lim = longint'(1) << (BC - 1);
        s = (acc >= lim) || (acc < -lim);
        acc = (acc >= lim) ? lim - 1 : (acc < -lim) ? -lim : acc;
        return acc >>> (BC - by);
    endfunction

    function automatic logic [CW-1:0] pk(input int k, input logic [BC-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        r[k*BC +: BC] = v;
        return r;
    endfunction

    task automatic step(input bit v, input logic [BT-1:0] t, input logic [CW-1:0] c, input bit clr, input bit rst);
        ent_t e, o, z;
        bit s16, s8;
        longint r;
        rstn = !rst; in_valid = v; t_in = t; c_in = c; ovf_clr = clr;
        @(posedge clk); #1;
        if (rst) begin
            z = '{default: 0};
            pq.delete();
            for (int i = 0; i < L - 1; i++) pq.push_back(z);
            exp_v = 0; exp_y = '0; exp_y8 = '0; exp_ovf = 0; exp_ovf8 = 0;
        end else begin
            e.v = v;
            r = eval(t, c, BY, s16);  e.y  = BY'(r);  e.s  = s16;
            r = eval(t, c, BY8, s8);  e.y8 = BY8'(r); e.s8 = s8;
            pq.push_back(e);
            o = pq.pop_front();
            exp_v = o.v; exp_y = o.y; exp_y8 = o.y8;
            exp_ovf  = (o.v && o.s)  ? 1'b1 : clr ? 1'b0 : exp_ovf;
            exp_ovf8 = (o.v && o.s8) ? 1'b1 : clr ? 1'b0 : exp_ovf8;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, 0);
    endtask

    task automatic test_reset();
        step(0, '0, '0, 0, 1);
        step(0, '0, '0, 0, 1);
        chk++;
        if ({y_valid, ovf, y_out} !== {1'b0, 1'b0, 16'h0000})
            $display("FAIL reset: y_valid=%b ovf=%b y_out=%h, want 0 0 0000", y_valid, ovf, y_out);
        else pass++;
    endtask

    task automatic test_const();
        step(1, 16'h1234, pk(0, 16'h4000), 0, 0);
        for (int i = 1; i < L; i++) begin
            step(0, '0, '0, 0, 0);
            chk++;
            if (y_valid !== (i == L - 1)) $display("FAIL const_latency i=%0d: y_valid=%b want %b", i, y_valid, i == L - 1);
            else pass++;
        end
        chk++;
        if (y_out !== 16'h4000 || ovf !== 1'b0) $display("FAIL const: y_out=%h ovf=%b, want 4000 0", y_out, ovf);
        else pass++;
    endtask

    task automatic test_trunc();
        step(1, 16'hFFFF, pk(5, 16'h7FFF), 0, 0);
        idle(L - 1);
        chk++;
        if ({y_valid, y_out, ovf} !== {1'b1, 16'h7FFA, 1'b0})
            $display("FAIL trunc: y_valid=%b y_out=%h ovf=%b, want 1 7ffa 0", y_valid, y_out, ovf);
        else pass++;
    endtask

    task automatic test_saturation();
        step(1, 16'h8000, pk(0, 16'h7FFF) | pk(1, 16'h7FFF), 0, 0);
        idle(L - 1);
        chk++;
        if ({y_valid, y_out, ovf} !== {1'b1, 16'h7FFF, 1'b1})
            $display("FAIL pos_sat: y_valid=%b y_out=%h ovf=%b, want 1 7fff 1", y_valid, y_out, ovf);
        else pass++;
        idle(5);
        chk++;
        if (ovf !== 1'b1) $display("FAIL ovf_sticky: ovf=%b want 1", ovf); else pass++;
        step(0, '0, '0, 1, 0);
        chk++;
        if (ovf !== 1'b0) $display("FAIL ovf_clr: ovf=%b want 0", ovf); else pass++;
        step(1, 16'h8000, pk(0, 16'h8000) | pk(1, 16'h8000), 0, 0);
        idle(L - 2);
        step(0, '0, '0, 1, 0);
        chk++;
        if ({y_valid, y_out, ovf} !== {1'b1, 16'h8000, 1'b1})
            $display("FAIL neg_sat_set_wins: y_valid=%b y_out=%h ovf=%b, want 1 8000 1", y_valid, y_out, ovf);
        else pass++;
        step(0, '0, '0, 1, 0);
        chk++;
        if (ovf !== 1'b0) $display("FAIL ovf_clr2: ovf=%b want 0", ovf); else pass++;
    endtask

    task automatic test_bubbles();
        bit vs[4] = '{1, 0, 1, 1};
        logic [BC-1:0] c0[4];
        c0 = '{16'd1, 16'($urandom), 16'd2, 16'd3};
        for (int i = 0; i < L + 3; i++) begin
            if (i < 4) step(vs[i], BT'($urandom), pk(0, c0[i]), 0, 0);
            else step(0, '0, '0, 0, 0);
            if (i >= L - 1) begin
                chk++;
                if (y_valid !== vs[i-L+1] || (vs[i-L+1] && y_out !== c0[i-L+1]))
                    $display("FAIL bubbles j=%0d: y_valid=%b y_out=%h, want %b %h", i - L + 1, y_valid, y_out, vs[i-L+1], c0[i-L+1]);
                else pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1, 16'h8000, pk(0, 16'h7FFF) | pk(1, 16'h7FFF), 0, 0);
        idle(3);
        step(0, '0, '0, 0, 1);
        for (int i = 0; i < L + 4; i++) begin
            step(0, '0, '0, 0, 0);
            chk++;
            if ({y_valid, y_out, ovf} !== {1'b0, 16'h0000, 1'b0})
                $display("FAIL reset_mid i=%0d: y_valid=%b y_out=%h ovf=%b, want 0 0000 0", i, y_valid, y_out, ovf);
            else pass++;
        end
    endtask

    task automatic test_round();
        logic [BY8-1:0] want;
`ifdef MAC_POLY_ROUND_EN
        want = 8'h01;
`else
        want = 8'h00;
`endif
        step(1, '0, pk(0, 16'h0080), 0, 0);
        idle(L - 1);
        chk++;
        if (y_valid8 !== 1'b1 || y_out8 !== want || y_out !== 16'h0080)
            $display("FAIL round: y_out8=%h y_out=%h y_valid8=%b, want %h 0080 1", y_out8, y_out, y_valid8, want);
        else pass++;
    endtask

    task automatic test_random();
        logic [CW-1:0] c;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k <= ORDER; k++) c[k*BC +: BC] = 16'($signed(16'($urandom)) >>> $urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, BT'($urandom), c, $urandom_range(0, 7) == 0, 0);
            chk++;
            if ({y_valid, y_out, ovf, y_valid8, y_out8, ovf8} !== {exp_v, exp_y, exp_ovf, exp_v, exp_y8, exp_ovf8})
                $display("FAIL random n=%0d: got v=%b y=%h o=%b v8=%b y8=%h o8=%b, want v=%b y=%h o=%b y8=%h o8=%b",
                         n, y_valid, y_out, ovf, y_valid8, y_out8, ovf8, exp_v, exp_y, exp_ovf, exp_y8, exp_ovf8);
            else pass++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_const();
        test_trunc();
        test_saturation();
        test_bubbles();
        test_reset_mid();
        test_round();
        test_random();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule

// File: doc/mac_poly_n.md
Name: mac_poly_n

Overview:
- Parametrised Horner-form polynomial evaluator: y = c0 + (c1 + (... + cN*t)*t ...)*t, with N = ORDER selectable at elaboration.
- Fully pipelined: one evaluation per clock. Input valid is carried through the pipeline, with bubbles allowed.
- Output is saturated, not truncated, and a sticky overflow flag is provided.
- Sits in the signal-generator envelope/amplitude path. t comes from the phase/time counter; coefficients come from the segment-parameter registers.

Parameters:
- ORDER, 5, polynomial order N (1..8); number of MAC stages.
- BC, 16, coefficient width; signed Q1.(BC-1).
- BT, 16, t width; unsigned Q0.BT, range [0,1).
- BY, 16, output width; signed, BY <= BC.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- t_in  in  BT  evaluation point
- c_in  in  (ORDER+1)*BC  packed coefficients; c_k at bits [k*BC +: BC]
- in_valid  in  1  t_in/c_in valid this cycle
- ovf_clr  in  1  clears the sticky ovf flag
- y_out  out  BY  polynomial result
- y_valid  out  1  y_out valid
- ovf  out  1  sticky saturation flag

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk. While rstn=0, all pipeline data registers, valid shift bits, y_out, y_valid and ovf are 0 on the next edge. In-flight samples are discarded; nothing emerges after reset is released until new in_valid.
- Internal width: BADD = BC + BGUARD, with BGUARD = clog2(ORDER+1). |y_k| <= k+1, so no internal wrap is possible for legal inputs. All c_k are sign-extended to BADD.
- Stage k runs for k = 0..ORDER-1 and computes y_{k+1} = c_{ORDER-1-k} + ((y_k * t) >>> BT), with y_0 = c_ORDER.
  - Arithmetic shift; truncation toward minus infinity. t is zero-extended to signed for the multiply.
- Each stage has a fixed 3-cycle latency:
  - cycle 1: input register.
  - cycle 2: product register (BADD+BT+1 bits).
  - cycle 3: sum register.
  - t is forwarded alongside with matching 3-cycle delay.
- Coefficient c_{ORDER-1-k} is delayed 3*k cycles before stage k. c_ORDER is not delayed.
- Total latency L = 3*ORDER + 1, including the output register. ORDER=5 gives L=16.
- in_valid enters a length-L shift register; y_valid is its output. Bubbles pass through unchanged.
- There is no backpressure. Data registers advance every cycle regardless of valid; only valid gates ovf.
- Output quantisation:
  - Saturate y_ORDER to signed BC range [-2^(BC-1), 2^(BC-1)-1].
  - Then take bits [BC-1 -: BY].
- ovf: set on any cycle where the valid final sample saturated. Held until ovf_clr=1.
  - ovf_clr and a new saturation in the same cycle: set wins (ovf stays 1).
- Boundaries:
  - t=0 gives y=c0 exactly.
  - ORDER=1 gives a single stage, L=4.
  - c_in changing every cycle is legal; each sample uses the coefficients presented with its own t_in.

Optional Feature:
- Macro MAC_POLY_ROUND_EN.
- Defined: final quantisation adds 2^(BC-BY-1) before bit selection (round-half-up), with saturation applied after the add. When BY=BC this is a no-op. Latency is unchanged.
- Undefined: plain truncation as above.

Decomposition:
- Package mac_poly_pkg holds:
  - function clog2_guard(order) returning BGUARD;
  - localparam STAGE_LAT = 3;
  - function total_lat(order) = 3*order+1;
  - saturate function sat_bc(value, badd, bc).
- One sub-module, poly_stage (one Horner MAC stage with t forwarding), instantiated ORDER times via generate.
- Coefficient delay lines are inline generate shift registers.

Test Plan (ORDER=5, BC=BT=BY=16):
- Constant term: c0=0x4000, all other c=0, t=0x1234, in_valid pulse. Expect y_out=0x4000 and y_valid=1 exactly 16 cycles later, ovf=0.
- Truncation chain: c5=0x7FFF, others 0, t=0xFFFF. Expect y_out=0x7FFA, ovf=0.
- Positive saturation: c0=c1=0x7FFF, others 0, t=0x8000. Internal 49150 gives y_out=0x7FFF, ovf=1. ovf stays 1 until an ovf_clr pulse.
- Negative saturation: c0=c1=0x8000, t=0x8000. Internal -49152 gives y_out=0x8000, ovf=1. ovf_clr in the same cycle as the saturating output leaves ovf=1.
- Bubbles and per-sample coefficients: in_valid 1,0,1,1 with c0=1,-,2,3 (others 0). Expect y_valid 1,0,1,1 starting at cycle 16, with y_out=1,x,2,3.
- Reset mid-flight: issue 5 valid samples, assert rstn=0 for 1 cycle at cycle 8. Expect y_valid=0, y_out=0 and ovf=0 thereafter, with no stale output.
- Round variant: with MAC_POLY_ROUND_EN and BY=8, c0=0x0080, t=0. Expect y_out=0x01; without the macro, expect y_out=0x00.
